// File: rtl/mem_req_ctrl_if.sv
// Pipeline-side and memory-side signals of the MEM-stage request controller.
// The controller takes the slave view; the pipeline/memory environment takes the master view.
interface mem_req_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_memop;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_memop, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output stall, resp_valid, resp_rdata, fault,
    output mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_memop, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  stall, resp_valid, resp_rdata, fault,
    input  mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// MEM-stage load/store controller: one doubleword-aligned memory access per request.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of rounding the offset down.
module mem_req_ctrl (
  input  logic          clk,
  input  logic          rst,
  mem_req_ctrl_if.slave bus
);
  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_D  = 3'd3;
  localparam logic [2:0] MEM_UB = 3'd4;
  localparam logic [2:0] MEM_UH = 3'd5;
  localparam logic [2:0] MEM_UW = 3'd6;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_n;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  wmask_q;
  logic        we_q;
  logic [2:0]  off_q;

  logic [2:0]  off_raw, amask, off_eff;
  logic [7:0]  mask_base, wmask_n;
  logic [63:0] wdata_n;
  logic        trap, rd_cap;

  // Low offset bits that must be zero for the access size (size-1).
  always_comb begin
    amask = 3'b000;
    case (bus.req_memop)
      MEM_H, MEM_UH: amask = 3'b001;
      MEM_W, MEM_UW: amask = 3'b011;
      MEM_D:         amask = 3'b111;
      default:       amask = 3'b000;
    endcase
  end

  // Only signed-size store codes produce byte enables; unsigned codes complete with an empty mask.
  always_comb begin
    mask_base = 8'h00;
    case (bus.req_memop)
      MEM_B:   mask_base = 8'h01;
      MEM_H:   mask_base = 8'h03;
      MEM_W:   mask_base = 8'h0F;
      MEM_D:   mask_base = 8'hFF;
      default: mask_base = 8'h00;
    endcase
  end

  always_comb begin
    off_raw = bus.req_addr[2:0];
    off_eff = off_raw & ~amask;
    wmask_n = bus.req_we ? (mask_base << off_eff) : 8'h00;
    wdata_n = bus.req_wdata << {off_eff, 3'b000};
`ifdef MISALIGN_TRAP_EN
    trap    = |(off_raw & amask);
`else
    trap    = 1'b0;
`endif
  end

  assign rd_cap = bus.mem_resp_valid &&
                  ((state == REQ && bus.mem_req_ready) || state == WAIT);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.req_valid)       state_n = trap ? DONE : REQ;
      REQ:  if (bus.mem_req_ready)   state_n = bus.mem_resp_valid ? DONE : WAIT;
      WAIT: if (bus.mem_resp_valid)  state_n = DONE;
      DONE:                          state_n = IDLE;
      default:                       state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.stall         = bus.req_valid;
    case (state)
      REQ:  bus.mem_req_valid = 1'b1;
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.stall      = 1'b0;
      end
      default: ;
    endcase
  end

  // Request fields are latched once at accept so they stay stable through REQ.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        addr_q  <= {bus.req_addr[63:3], 3'b000};
        wdata_q <= wdata_n;
        wmask_q <= wmask_n;
        we_q    <= bus.req_we;
        off_q   <= off_eff;
      end
      if (rd_cap) rdata_q <= bus.mem_rdata >> {off_q, 3'b000};
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic fault_q;
  always_ff @(posedge clk) begin
    if (!rst)                              fault_q <= 1'b0;
    else if (state == IDLE && bus.req_valid) fault_q <= trap;
  end
  assign bus.fault = fault_q && (state == DONE);
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wmask  = wmask_q;
  assign bus.mem_we     = we_q;
  assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl; inputs change 1ns after each rising edge, checks follow 1ns later.
module tb_mem_req_ctrl;
  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_D  = 3'd3;
  localparam logic [2:0] MEM_UB = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  mem_req_ctrl_if bus();

  mem_req_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic we, input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_memop = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_mrv"},   {63'd0, bus.mem_req_valid}, 64'd0);
    chk({tag, "_rv"},    {63'd0, bus.resp_valid},    64'd0);
    chk({tag, "_fault"}, {63'd0, bus.fault},         64'd0);
    chk({tag, "_rdata"}, bus.resp_rdata,             64'd0);
    chk({tag, "_mask"},  {56'd0, bus.mem_wmask},     64'd0);
    chk({tag, "_addr"},  bus.mem_addr,               64'd0);
    chk({tag, "_wdata"}, bus.mem_wdata,              64'd0);
    chk({tag, "_we"},    {63'd0, bus.mem_we},        64'd0);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_memop = MEM_B;
    bus.req_addr = 0; bus.req_wdata = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0;

    tick(); tick();
    settle();
    chk_reset_outs("rst");
    rst = 1'b1;
    tick();

    // Load word at 0x1004, response one cycle after ready.
    set_req(1'b0, MEM_W, 64'h1004, 64'd0);
    settle();
    chk("ldw_idle_stall", {63'd0, bus.stall}, 64'd1);
    tick();
    bus.mem_req_ready = 1'b1;
    settle();
    chk("ldw_mrv",  {63'd0, bus.mem_req_valid}, 64'd1);
    chk("ldw_addr", bus.mem_addr, 64'h1000);
    chk("ldw_mask", {56'd0, bus.mem_wmask}, 64'd0);
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 64'h89ABCDEF_01234567;
    settle();
    chk("ldw_wait_mrv",   {63'd0, bus.mem_req_valid}, 64'd0);
    chk("ldw_wait_stall", {63'd0, bus.stall}, 64'd1);
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("ldw_rv",    {63'd0, bus.resp_valid}, 64'd1);
    chk("ldw_rdata", bus.resp_rdata, 64'h00000000_89ABCDEF);
    chk("ldw_stall", {63'd0, bus.stall}, 64'd0);
    bus.req_valid = 1'b0;
    tick();
    settle();
    chk("ldw_rv_1cyc", {63'd0, bus.resp_valid}, 64'd0);

    // Store byte at 0x2003 with ready held low for three cycles.
    set_req(1'b1, MEM_B, 64'h2003, 64'hAA);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.mem_req_ready = (i == 3);
      settle();
      chk($sformatf("stb_mrv%0d", i),   {63'd0, bus.mem_req_valid}, 64'd1);
      chk($sformatf("stb_addr%0d", i),  bus.mem_addr, 64'h2000);
      chk($sformatf("stb_mask%0d", i),  {56'd0, bus.mem_wmask}, 64'h08);
      chk($sformatf("stb_wdata%0d", i), bus.mem_wdata, 64'h00000000_AA000000);
      chk($sformatf("stb_we%0d", i),    {63'd0, bus.mem_we}, 64'd1);
      chk($sformatf("stb_stall%0d", i), {63'd0, bus.stall}, 64'd1);
      tick();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    settle();
    chk("stb_wait_stall", {63'd0, bus.stall}, 64'd1);
    chk("stb_wait_rv",    {63'd0, bus.resp_valid}, 64'd0);
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("stb_rv",    {63'd0, bus.resp_valid}, 64'd1);
    chk("stb_stall", {63'd0, bus.stall}, 64'd0);
    bus.req_valid = 1'b0;
    tick();

    // Load doubleword, ready and response together: IDLE, REQ, DONE.
    set_req(1'b0, MEM_D, 64'h4000, 64'd0);
    tick();
    bus.mem_req_ready = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 64'h11223344_55667788;
    settle();
    chk("ldd_req_rv", {63'd0, bus.resp_valid}, 64'd0);
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("ldd_rv",    {63'd0, bus.resp_valid}, 64'd1);
    chk("ldd_rdata", bus.resp_rdata, 64'h11223344_55667788);
    bus.req_valid = 1'b0;
    tick();

    // Stray response while idle must not disturb the held read data.
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("stray_rv",    {63'd0, bus.resp_valid}, 64'd0);
    chk("stray_rdata", bus.resp_rdata, 64'h11223344_55667788);

    // Halfword store at odd offset 0x3001.
    set_req(1'b1, MEM_H, 64'h3001, 64'hBEEF);
    tick();
`ifdef MISALIGN_TRAP_EN
    settle();
    chk("sth_mrv",   {63'd0, bus.mem_req_valid}, 64'd0);
    chk("sth_rv",    {63'd0, bus.resp_valid}, 64'd1);
    chk("sth_fault", {63'd0, bus.fault}, 64'd1);
    chk("sth_rdata", bus.resp_rdata, 64'h11223344_55667788);
`else
    bus.mem_req_ready = 1'b1;
    bus.mem_resp_valid = 1'b1;
    settle();
    chk("sth_mrv",   {63'd0, bus.mem_req_valid}, 64'd1);
    chk("sth_mask",  {56'd0, bus.mem_wmask}, 64'h03);
    chk("sth_wdata", bus.mem_wdata, 64'h000000000000BEEF);
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("sth_rv",    {63'd0, bus.resp_valid}, 64'd1);
    chk("sth_fault", {63'd0, bus.fault}, 64'd0);
`endif
    bus.req_valid = 1'b0;
    tick();

    // Store with an unsigned code: empty byte mask, still completes.
    set_req(1'b1, MEM_UB, 64'h5002, 64'h55);
    tick();
    bus.mem_req_ready = 1'b1;
    settle();
    chk("stub_mrv",   {63'd0, bus.mem_req_valid}, 64'd1);
    chk("stub_mask",  {56'd0, bus.mem_wmask}, 64'h00);
    chk("stub_wdata", bus.mem_wdata, 64'h0000000000550000);
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("stub_rv", {63'd0, bus.resp_valid}, 64'd1);
    bus.req_valid = 1'b0;
    tick();

    // Reset during WAIT, then a late response after release.
    set_req(1'b0, MEM_W, 64'h6000, 64'd0);
    tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 64'h0123456789ABCDEF;
    settle();
    chk_reset_outs("wrst0");
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk_reset_outs("wrst1");
    chk("wrst_stall", {63'd0, bus.stall}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port req_valid  input  1  MEM stage holds a load/store.
REQ-004 SHALL have port req_we  input  1  1=store, 0=load.
REQ-005 SHALL have port req_memop  input  3  CorePack memop code (MEM_D/W/H/B/UW/UH/UB).
REQ-006 SHALL have port req_addr  input  64  byte address.
REQ-007 SHALL have port req_wdata  input  64  store data, lane-0 aligned.
REQ-008 SHALL have port stall  output  1  hold pipeline while access is in progress.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  output  64  load data shifted right by byte offset; raw, no extension; mem_ope performs extension.
REQ-011 SHALL have port fault  output  1  misaligned-access flag, valid with resp_valid.
REQ-012 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out 64 (bits[2:0]=0), mem_we out 1, mem_wmask out 8, mem_wdata out 64, mem_resp_valid in 1, mem_rdata in 64.

Function
REQ-013 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-014 IDLE: on req_valid, SHALL register we/memop/addr/wdata, offset off=addr[2:0]; next state REQ (or DONE with fault, REQ-024).
REQ-015 REQ: mem_req_valid=1, mem_addr={addr[63:3],3'b0}, mem_we/mask/wdata held stable until mem_req_ready=1.
REQ-016 REQ with mem_req_ready=1: next WAIT; if mem_resp_valid also 1 same cycle, SHALL capture mem_rdata and go directly to DONE.
REQ-017 WAIT: on mem_resp_valid SHALL capture mem_rdata>>(8*off) and go DONE; stores also wait for mem_resp_valid.
REQ-018 DONE: resp_valid=1, stall=0 for exactly one cycle, then IDLE.
REQ-019 stall SHALL be combinational: req_valid && state!=DONE; minimum access latency 3 cycles (IDLE->REQ->DONE).
REQ-020 mem_wmask: MEM_B 8'h01<<off, MEM_H 8'h03<<off, MEM_W 8'h0F<<off, MEM_D 8'hFF; loads 8'h00; store with unsigned memop SHALL give mask 8'h00 yet complete normally.
REQ-021 mem_wdata SHALL be req_wdata<<(8*off), truncated to 64 bits.
REQ-022 mem_resp_valid in IDLE or DONE SHALL be ignored; resp_rdata holds last captured value otherwise.

Reset
REQ-023 rst=0 at a rising edge SHALL force IDLE, mem_req_valid=0, resp_valid=0, fault=0, resp_rdata=0, mem_wmask=0, mem_addr=0, mem_wdata=0, mem_we=0; aborts any in-flight access, later stray responses ignored per REQ-022.

Configuration
REQ-024 With MISALIGN_TRAP_EN defined: access with off not a multiple of access size (H:2, W:4, D:8) SHALL issue no memory request; IDLE->DONE with fault=1, resp_rdata unchanged.
REQ-025 Without MISALIGN_TRAP_EN: off SHALL be rounded down to access-size alignment before mask/shift; fault tied to 0.

Verification
REQ-026 Load MEM_W addr 0x1004, mem_rdata=0x89ABCDEF_01234567 one cycle after ready -> mem_addr=0x1000, resp_rdata=0x00000000_89ABCDEF, resp_valid one cycle.
REQ-027 Store MEM_B addr 0x2003 wdata 0xAA, ready held 0 for 3 cycles -> request stable 4 cycles, mem_wmask=8'h08, mem_wdata=0x00000000_AA000000, stall high until DONE.
REQ-028 Load MEM_D with ready and resp_valid in same REQ cycle -> IDLE, REQ, DONE; 3-cycle latency.
REQ-029 MEM_H addr 0x3001: with MISALIGN_TRAP_EN -> no mem_req_valid, fault=1 at resp_valid; without -> mem_wmask/shift use off=0, fault=0.
REQ-030 rst=0 asserted in WAIT, then mem_resp_valid=1 after release -> FSM IDLE, no resp_valid, all outputs at reset values.
